gray_line_window3: RTL and testbench
====================================

// Module: gray_line_window3
// PURPOSE
//  Sits directly downstream of the RGB-to-grayscale stage. Consumes its 4-pixel/beat gray AXI-Stream
//  and buffers the two previous image lines in on-chip line memories. Emits a 3-row vertical window
//  (rows n-2, n-1, n at the same column beat) for the stereo census/SAD stages that follow.
// PARAMETERS
//  C_S_AXIS_gray_TDATA_WIDTH  32   input beat: 4 gray pixels x 8 bit (fixed)
//  C_M_AXIS_win_TDATA_WIDTH   96   output beat: 3 rows x 32 bit (fixed)
//  MAX_LINE_BEATS             480  line-memory depth in beats (1920 px / 4)
//  ADDR_WIDTH                 9    column counter width, >= clog2(MAX_LINE_BEATS)
// PORTS
//  aclk                 in   1   single clock, all logic rising-edge
//  aresetn              in   1   asynchronous active-low reset
//  s_axis_gray_tdata    in   32  4 gray pixels, pixel0 in [7:0] ... pixel3 in [31:24]
//  s_axis_gray_tvalid   in   1   input beat valid
//  s_axis_gray_tready   out  1   input beat accepted when tvalid & tready
//  s_axis_gray_tuser    in   1   start of frame, first beat of row 0
//  s_axis_gray_tlast    in   1   last beat of a line
//  m_axis_win_tdata     out  96  [31:0]=row n-2, [63:32]=row n-1, [95:64]=row n, same column beat
//  m_axis_win_tvalid    out  1   window beat valid
//  m_axis_win_tready    in   1   downstream ready
//  m_axis_win_tuser     out  1   first window beat of frame (row 2, column 0)
//  m_axis_win_tlast     out  1   last window beat of a line
//  err_overflow         out  1   sticky: line exceeded MAX_LINE_BEATS; cleared only by reset or tuser
// BEHAVIOUR
//  Reset (aresetn=0, async): m_axis_win_tvalid/tuser/tlast=0, tdata=0, err_overflow=0,
//   s_axis_gray_tready=0, col=0, row_cnt=0, both pipeline stages empty.
//   Line memories are not reset; their contents are never exposed before being rewritten in the current frame.
//  Pipeline: 2 stages, single enable en = !m_axis_win_tvalid | m_axis_win_tready;
//   s_axis_gray_tready = en (and 0 during reset). All stages hold while en=0, with no data loss.
//   Latency: accepted beat -> m_axis_win_tvalid exactly 2 cycles later when downstream never stalls.
//   Throughput: 1 beat/cycle sustained.
//  Line memories LB_TOP, LB_MID (MAX_LINE_BEATS x 32, read-first, sync read).
//   On each accepted beat at column col, the window is {in, LB_MID[col], LB_TOP[col]} (old values).
//   Then LB_TOP[col] <= old LB_MID[col] and LB_MID[col] <= in. The delayed write in stage 2 is permitted,
//   but a read in the following cycle at the same col must see the new data (bypass).
//  Counters, updated on accepted beats only:
//   - tuser=1: this beat is col 0 of row 0; row_cnt <- 0; col restarts; err_overflow cleared.
//     A mid-line tuser aborts the line in progress.
//   - tlast=1: col <- 0 and row_cnt <- min(row_cnt+1, 2) after this beat.
//     tuser and tlast on the same beat: the beat is the single beat of row 0, and row_cnt becomes 1.
//   - Otherwise col <- col+1. At col = MAX_LINE_BEATS-1 without tlast, col holds;
//     further beats overwrite that address and set err_overflow.
//  Output gating: a beat produces an output only if its row index >= 2 (row_cnt==2 at acceptance).
//   Beats of rows 0 and 1 are consumed without output: they fill the memories, and m_axis_win_tvalid stays 0.
//  m_axis_win_tuser = 1 on the output beat for row 2, col 0 only. m_axis_win_tlast = input tlast of that beat.
//  Input beats with tvalid=0 change no state. Input tdata is not width-converted; pixel order is preserved per row.
// TESTING
//  1) Reset: hold aresetn=0 with random inputs -> all outputs 0. Release -> s_axis_gray_tready=1 next cycle.
//  2) Frame 4 beats x 4 lines, line L beat c data = {L,c,L,c} bytes, no stalls. Expected:
//     first 8 beats give no output; beat (2,0) gives tdata {row2,row1,row0} at col 0 with tuser=1,
//     2 cycles after acceptance; 8 window beats in total; tlast on c=3.
//  3) As test 2 with m_axis_win_tready toggled 1010... and random input gaps
//     -> identical output sequence, no drop or duplicate, s_axis_gray_tready=0 whenever output is held.
//  4) tuser on beat 2 of line 3 -> old line aborted; next outputs appear only after 2 new lines,
//     first one with tuser=1.
//  5) Line of MAX_LINE_BEATS+2 beats -> err_overflow=1 from beat MAX_LINE_BEATS+1, held until the next tuser.
//  6) Single-beat lines (tuser&tlast, then tlast each beat) -> output on the 3rd beat containing
//     beats 1..3 of the frame (top = beat 1).

Source files
------------

// File: rtl/gray_line_window3_if.sv
// ============================================================================
// Module   : gray_line_window3_if
// Brief    : AXI-Stream style beat bundle (data/valid/ready/user/last).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_line_window3_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/gray_line_window3.sv
// ============================================================================
// Module   : gray_line_window3
// Brief    : Two-line buffer producing a 3-row vertical window per column beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_line_window3 #(
    parameter int C_S_AXIS_gray_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_win_TDATA_WIDTH  = 96,
    parameter int MAX_LINE_BEATS            = 480,
    parameter int ADDR_WIDTH                = 9
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    gray_line_window3_if.slave        s_axis_gray,
    gray_line_window3_if.master       m_axis_win,
    output logic                      err_overflow
);
    localparam int                    c_dw       = C_S_AXIS_gray_TDATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_col = ADDR_WIDTH'(MAX_LINE_BEATS - 1);

    logic                                r_rst_done;
    logic [ADDR_WIDTH-1:0]               r_col;
    logic                                r_col_full;
    // Row index saturates at 3 so that row 2 (first output row) stays distinguishable.
    logic [1:0]                          r_row_idx;

    logic                                r_s1_valid;
    logic                                r_s1_out;
    logic                                r_s1_user;
    logic                                r_s1_last;
    logic [c_dw-1:0]                     r_s1_data;
    logic [ADDR_WIDTH-1:0]               r_s1_addr;
    logic [c_dw-1:0]                     r_rd_mid;
    logic [c_dw-1:0]                     r_rd_top;

    logic                                r_m_tvalid;
    logic                                r_m_tuser;
    logic                                r_m_tlast;
    logic [C_M_AXIS_win_TDATA_WIDTH-1:0] r_m_tdata;

    logic [c_dw-1:0]                     r_lb_top [MAX_LINE_BEATS];
    logic [c_dw-1:0]                     r_lb_mid [MAX_LINE_BEATS];

    logic                                w_en;
    logic                                w_accept;
    logic                                w_wr_en;
    logic                                w_full_eff;
    logic [ADDR_WIDTH-1:0]               w_col_eff;
    logic [1:0]                          w_row_eff;

    assign w_en              = !r_m_tvalid || m_axis_win.tready;
    assign s_axis_gray.tready = w_en && r_rst_done;
    assign w_accept          = s_axis_gray.tvalid && s_axis_gray.tready;
    assign w_wr_en           = w_en && r_s1_valid;
    assign w_col_eff         = s_axis_gray.tuser ? '0 : r_col;
    assign w_row_eff         = s_axis_gray.tuser ? 2'd0 : r_row_idx;
    assign w_full_eff        = !s_axis_gray.tuser && r_col_full;

    assign m_axis_win.tvalid = r_m_tvalid;
    assign m_axis_win.tuser  = r_m_tuser;
    assign m_axis_win.tlast  = r_m_tlast;
    assign m_axis_win.tdata  = r_m_tdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done   <= 1'b0;
            r_col        <= '0;
            r_col_full   <= 1'b0;
            r_row_idx    <= 2'd0;
            r_s1_valid   <= 1'b0;
            r_s1_out     <= 1'b0;
            r_s1_user    <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_data    <= '0;
            r_s1_addr    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tuser    <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            err_overflow <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_s1_data    <= s_axis_gray.tdata;
                r_s1_addr    <= w_col_eff;
                r_s1_out     <= w_row_eff[1];
                r_s1_user    <= (w_row_eff == 2'd2) && (w_col_eff == '0);
                r_s1_last    <= s_axis_gray.tlast;
                err_overflow <= w_full_eff || (err_overflow && !s_axis_gray.tuser);
                if (s_axis_gray.tlast) begin
                    r_col      <= '0;
                    r_col_full <= 1'b0;
                    r_row_idx  <= (w_row_eff == 2'd3) ? 2'd3 : w_row_eff + 2'd1;
                end else if (w_col_eff == c_last_col) begin
                    r_col      <= w_col_eff;
                    r_col_full <= 1'b1;
                    r_row_idx  <= w_row_eff;
                end else begin
                    r_col      <= w_col_eff + 1'b1;
                    r_col_full <= 1'b0;
                    r_row_idx  <= w_row_eff;
                end
            end
            if (w_en) begin
                r_s1_valid <= w_accept;
                r_m_tvalid <= r_s1_valid && r_s1_out;
                r_m_tuser  <= r_s1_valid && r_s1_user;
                r_m_tlast  <= r_s1_valid && r_s1_out && r_s1_last;
                if (r_s1_valid && r_s1_out) begin
                    r_m_tdata <= {r_s1_data, r_rd_mid, r_rd_top};
                end
            end
        end
    end

    // Stage-2 write lands on the same edge as the next read; forward it when addresses match.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_lb_top[r_s1_addr] <= r_rd_mid;
            r_lb_mid[r_s1_addr] <= r_s1_data;
        end
        if (w_accept) begin
            if (w_wr_en && (r_s1_addr == w_col_eff)) begin
                r_rd_top <= r_rd_mid;
                r_rd_mid <= r_s1_data;
            end else begin
                r_rd_top <= r_lb_top[w_col_eff];
                r_rd_mid <= r_lb_mid[w_col_eff];
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_gray_line_window3.sv
// ============================================================================
// Module   : tb_gray_line_window3
// Brief    : Randomized self-checking bench with a row-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_line_window3;
    localparam int MAXB = 480;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic err_overflow;

    gray_line_window3_if #(.DATA_WIDTH(32)) s_if ();
    gray_line_window3_if #(.DATA_WIDTH(96)) m_if ();

    gray_line_window3 #(
        .C_S_AXIS_gray_TDATA_WIDTH (32),
        .C_M_AXIS_win_TDATA_WIDTH  (96),
        .MAX_LINE_BEATS            (MAXB),
        .ADDR_WIDTH                (9)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_gray  (s_if.slave),
        .m_axis_win   (m_if.master),
        .err_overflow (err_overflow)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: rows of the current frame, window = same column of rows r, r-1, r-2.
    typedef struct {
        logic [95:0] data;
        logic        user;
        logic        last;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] lines [3][MAXB];
    int          m_row = 0;
    int          m_col = 0;
    logic        m_ovf = 1'b0;
    int          ready_mode = 0;
    bit          lat_check  = 1'b0;
    int          out_cnt    = 0;

    task automatic model_accept(input logic [31:0] d, input logic u, input logic l, input int acc);
        int   a;
        exp_t e;
        if (u) begin
            m_row = 0;
            m_col = 0;
            m_ovf = 1'b0;
        end
        a = (m_col < MAXB) ? m_col : MAXB - 1;
        if (m_col >= MAXB) m_ovf = 1'b1;
        lines[m_row % 3][a] = d;
        if (m_row >= 2) begin
            e.data = {lines[m_row % 3][a], lines[(m_row - 1) % 3][a], lines[(m_row - 2) % 3][a]};
            e.user = (m_row == 2) && (m_col == 0);
            e.last = l;
            e.acc  = acc;
            exp_q.push_back(e);
        end
        if (l) begin
            m_row++;
            m_col = 0;
        end else begin
            m_col++;
        end
    endtask

    always @(posedge aclk) begin
        #1;
        if (!aresetn)             m_if.tready = 1'($urandom_range(0, 1));
        else if (ready_mode == 0) m_if.tready = 1'b1;
        else if (ready_mode == 1) m_if.tready = ~m_if.tready;
        else                      m_if.tready = 1'($urandom_range(0, 1));
    end

    always @(negedge aclk) begin : mon
        exp_t e;
        if (aresetn) begin
            if (m_if.tvalid && !m_if.tready) chk("hold_ready", 96'(s_if.tready), 96'd0);
            if (m_if.tvalid && m_if.tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_out", 96'(m_if.tvalid), 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_data", m_if.tdata, e.data);
                    chk("win_user", 96'(m_if.tuser), 96'(e.user));
                    chk("win_last", 96'(m_if.tlast), 96'(e.last));
                    if (lat_check) chk("latency", 96'(cyc - e.acc), 96'd2);
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input int max_gap);
        int n = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_if.tready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 96'(s_if.tready), 96'd1);
                break;
            end
        end
        if (s_if.tready) model_accept(d, u, l, cyc);
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = $urandom;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(negedge aclk);
        chk("drain", 96'(exp_q.size()), 96'd0);
    endtask

    function automatic logic [31:0] pat(input int line, input int col);
        return {8'(line), 8'(col), 8'(line), 8'(col)};
    endfunction

    task automatic send_pattern_frame(input int max_gap);
        for (int ln = 0; ln < 4; ln++)
            for (int c = 0; c < 4; c++)
                send_beat(pat(ln, c), 1'(ln == 0 && c == 0), 1'(c == 3), max_gap);
    endtask

    task automatic send_rand_frame(input int nlines, input int nbeats, input int max_gap);
        for (int ln = 0; ln < nlines; ln++)
            for (int c = 0; c < nbeats; c++)
                send_beat($urandom, 1'(ln == 0 && c == 0), 1'(c == nbeats - 1), max_gap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            s_if.tvalid = 1'($urandom_range(0, 1));
            s_if.tuser  = 1'($urandom_range(0, 1));
            s_if.tlast  = 1'($urandom_range(0, 1));
            s_if.tdata  = $urandom;
            @(negedge aclk);
            chk("rst_tvalid", 96'(m_if.tvalid), 96'd0);
            chk("rst_tuser",  96'(m_if.tuser),  96'd0);
            chk("rst_tlast",  96'(m_if.tlast),  96'd0);
            chk("rst_tdata",  m_if.tdata,       96'd0);
            chk("rst_err",    96'(err_overflow), 96'd0);
            chk("rst_sready", 96'(s_if.tready), 96'd0);
        end
        @(posedge aclk);
        #1;
        aresetn     = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge aclk);
        #1;
        chk("rel_sready", 96'(s_if.tready), 96'd1);

        // 4x4 pattern frame, no stalls, latency checked
        ready_mode = 0;
        lat_check  = 1'b1;
        out_cnt    = 0;
        send_pattern_frame(0);
        wait_drain();
        chk("t2_count", 96'(out_cnt), 96'd8);
        lat_check = 1'b0;

        // Same frame with toggling downstream ready and input gaps
        ready_mode = 1;
        out_cnt    = 0;
        send_pattern_frame(2);
        wait_drain();
        chk("t3_count", 96'(out_cnt), 96'd8);

        // Frame aborted by tuser mid-line
        ready_mode = 2;
        out_cnt    = 0;
        send_rand_frame(3, 4, 1);
        send_beat($urandom, 1'b0, 1'b0, 1);
        send_beat($urandom, 1'b0, 1'b0, 1);
        send_rand_frame(3, 4, 1);
        wait_drain();
        chk("t4_count", 96'(out_cnt), 96'd10);

        // Overflowing line
        ready_mode = 0;
        for (int c = 0; c < MAXB + 2; c++) begin
            send_beat($urandom, 1'(c == 0), 1'(c == MAXB + 1), 0);
            if (c >= MAXB - 3) chk("ovf_line", 96'(err_overflow), 96'(m_ovf));
        end
        for (int c = 0; c < 4; c++) send_beat($urandom, 1'b0, 1'(c == 3), 0);
        chk("ovf_sticky", 96'(err_overflow), 96'd1);
        out_cnt = 0;
        send_beat($urandom, 1'b1, 1'b0, 0);
        chk("ovf_clear", 96'(err_overflow), 96'd0);
        for (int c = 1; c < 4; c++) send_beat($urandom, 1'b0, 1'(c == 3), 0);
        for (int ln = 1; ln < 3; ln++)
            for (int c = 0; c < 4; c++) send_beat($urandom, 1'b0, 1'(c == 3), 0);
        wait_drain();
        chk("t5_count", 96'(out_cnt), 96'd4);

        // Single-beat lines, back to back then with gaps and random stalls
        for (int pass = 0; pass < 2; pass++) begin
            ready_mode = (pass == 0) ? 0 : 2;
            out_cnt    = 0;
            for (int b = 0; b < 6; b++) send_beat($urandom, 1'(b == 0), 1'b1, pass * 2);
            wait_drain();
            chk("t6_count", 96'(out_cnt), 96'd4);
        end

        // Random frames under random backpressure
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            out_cnt = 0;
            send_rand_frame(5, 5, 2);
            wait_drain();
            chk("rand_count", 96'(out_cnt), 96'd15);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
